// File: rtl/rf_wb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
// Optional bypass outputs are enabled with the RF_WB_BYPASS_EN macro (see rf_wb_arbiter.sv).
package rf_wb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    // Which requester owns the write port in a given cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_MEM  = 2'd1,
        GNT_EX   = 2'd2
    } grant_e;

    // One writeback request at the default widths.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] rd;
        logic [DATA_W_DEF-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_starve_cnt.sv
// Saturating count of consecutive cycles an EX request has been denied.
// ex_starved_o tells the arbiter to force the next EX grant.
module rf_wb_starve_cnt #(
    parameter int MAX_WAIT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ex_valid_i,
    input  logic ex_gnt_i,
    output logic ex_starved_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;

    // Next count: clear when EX is served or idle, otherwise count up to the ceiling.
    always_comb begin
        // NOTE: assign a default first so every path drives the signal and no latch is inferred.
        wait_cnt_d = wait_cnt_q;
        if (!ex_valid_i || ex_gnt_i) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign ex_starved_o = (wait_cnt_q == CNT_MAX);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between EX (ALU) and MEM (load) writebacks.
// MEM has priority; EX is forced through after MAX_WAIT denied cycles.
// Define RF_WB_BYPASS_EN to add same-cycle read bypass outputs off the output stage.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_hold,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wr_rg,
    output logic [DATA_W-1:0] rf_wr_data,
`ifdef RF_WB_BYPASS_EN
    input  logic [ADDR_W-1:0] byp_rg1,
    input  logic [ADDR_W-1:0] byp_rg2,
    output logic              byp_hit1,
    output logic              byp_hit2,
    output logic [DATA_W-1:0] byp_data1,
    output logic [DATA_W-1:0] byp_data2,
`endif
    output logic              ex_starved
);

    grant_e            gnt;
    logic              gnt_any;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    logic              rf_we_q,      rf_we_d;
    logic [ADDR_W-1:0] rf_wr_rg_q,   rf_wr_rg_d;
    logic [DATA_W-1:0] rf_wr_data_q, rf_wr_data_d;

    rf_wb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid_i   (ex_valid),
        .ex_gnt_i     (gnt == GNT_EX),
        .ex_starved_o (ex_starved)
    );

    // Grant selection: hold and reset block everything, starvation beats MEM priority.
    always_comb begin
        gnt = GNT_NONE;
        if (rst_n && !wb_hold) begin
            if (ex_valid && ex_starved) begin
                gnt = GNT_EX;
            end else if (mem_valid) begin
                gnt = GNT_MEM;
            end else if (ex_valid) begin
                gnt = GNT_EX;
            end
        end
    end

    assign ex_ready  = (gnt == GNT_EX);
    assign mem_ready = (gnt == GNT_MEM);
    assign gnt_any   = (gnt != GNT_NONE);
    assign sel_rd    = (gnt == GNT_MEM) ? mem_rd   : ex_rd;
    assign sel_data  = (gnt == GNT_MEM) ? mem_data : ex_data;

    // Output-stage next state: address/data hold when idle, x0 writes never raise rf_we.
    always_comb begin
        rf_we_d      = gnt_any && (sel_rd != '0);
        rf_wr_rg_d   = rf_wr_rg_q;
        rf_wr_data_d = rf_wr_data_q;
        if (gnt_any) begin
            rf_wr_rg_d   = sel_rd;
            rf_wr_data_d = sel_data;
        end
    end

    // Output register driving the register file; reset discards any pending write.
    always_ff @(posedge clk) begin
        // NOTE: the data/address flops are reset too, so the register file never sees X after reset.
        if (!rst_n) begin
            rf_we_q      <= 1'b0;
            rf_wr_rg_q   <= '0;
            rf_wr_data_q <= '0;
        end else begin
            rf_we_q      <= rf_we_d;
            rf_wr_rg_q   <= rf_wr_rg_d;
            rf_wr_data_q <= rf_wr_data_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_wr_rg   = rf_wr_rg_q;
    assign rf_wr_data = rf_wr_data_q;

`ifdef RF_WB_BYPASS_EN
    // Bypass matches against the in-flight write; x0 never hits.
    assign byp_hit1  = rf_we_q && (rf_wr_rg_q == byp_rg1) && (byp_rg1 != '0);
    assign byp_hit2  = rf_we_q && (rf_wr_rg_q == byp_rg2) && (byp_rg2 != '0);
    assign byp_data1 = rf_wr_data_q;
    assign byp_data2 = rf_wr_data_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (MAX_WAIT=3); bypass checks build when RF_WB_BYPASS_EN is defined.
module tb_rf_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wb_hold;
    logic              ex_valid, mem_valid;
    logic              ex_ready, mem_ready;
    logic [ADDR_W-1:0] ex_rd, mem_rd;
    logic [DATA_W-1:0] ex_data, mem_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wr_rg;
    logic [DATA_W-1:0] rf_wr_data;
    logic              ex_starved;
`ifdef RF_WB_BYPASS_EN
    logic [ADDR_W-1:0] byp_rg1, byp_rg2;
    logic              byp_hit1, byp_hit2;
    logic [DATA_W-1:0] byp_data1, byp_data2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_hold    (wb_hold),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_rd      (ex_rd),
        .ex_data    (ex_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .rf_we      (rf_we),
        .rf_wr_rg   (rf_wr_rg),
        .rf_wr_data (rf_wr_data),
`ifdef RF_WB_BYPASS_EN
        .byp_rg1    (byp_rg1),
        .byp_rg2    (byp_rg2),
        .byp_hit1   (byp_hit1),
        .byp_hit2   (byp_hit2),
        .byp_data1  (byp_data1),
        .byp_data2  (byp_data2),
`endif
        .ex_starved (ex_starved)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge; registered outputs are stable here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        wb_hold   = 1'b0;
        ex_valid  = 1'b1;  ex_rd  = 5'd1;  ex_data  = 32'h0000_1111;
        mem_valid = 1'b1;  mem_rd = 5'd2;  mem_data = 32'h0000_2222;
`ifdef RF_WB_BYPASS_EN
        byp_rg1 = '0;
        byp_rg2 = '0;
`endif

        // Reset held for two cycles with both requesters valid.
        tick();
        tick();
        check("rst_ex_ready",  ex_ready,   1'b0);
        check("rst_mem_ready", mem_ready,  1'b0);
        check("rst_rf_we",     rf_we,      1'b0);
        check("rst_rf_wr_rg",  rf_wr_rg,   5'd0);
        check("rst_rf_data",   rf_wr_data, 32'd0);
        check("rst_starved",   ex_starved, 1'b0);

        // First grant after release goes to MEM.
        rst_n = 1'b1;
        settle();
        check("rel_mem_ready", mem_ready, 1'b1);
        check("rel_ex_ready",  ex_ready,  1'b0);
        tick();
        mem_valid = 1'b0;
        check("rel_rf_we",    rf_we,      1'b1);
        check("rel_rf_wr_rg", rf_wr_rg,   5'd2);
        check("rel_rf_data",  rf_wr_data, 32'h0000_2222);
        settle();
        check("rel_ex_next",  ex_ready,   1'b1);
        tick();
        ex_valid = 1'b0;
        check("rel_ex_rg",    rf_wr_rg,   5'd1);
        tick();
        check("rel_idle_we",  rf_we,      1'b0);

        // Single EX request.
        ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEAD_BEEF;
        settle();
        check("ex1_ex_ready",  ex_ready,  1'b1);
        check("ex1_mem_ready", mem_ready, 1'b0);
        tick();
        ex_valid = 1'b0;
        check("ex1_rf_we",   rf_we,      1'b1);
        check("ex1_rf_rg",   rf_wr_rg,   5'd5);
        check("ex1_rf_data", rf_wr_data, 32'hDEAD_BEEF);
        tick();
        check("ex1_we_off",  rf_we,      1'b0);
        check("ex1_rg_hold", rf_wr_rg,   5'd5);
        check("ex1_dat_hold", rf_wr_data, 32'hDEAD_BEEF);

        // Contention: MEM wins three cycles, then EX is forced through.
        ex_valid = 1'b1; ex_rd = 5'd9; ex_data = 32'h0000_0099;
        mem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_rd = 5'(10 + i); mem_data = 32'(i);
            settle();
            check("cont_mem_ready", mem_ready,  1'b1);
            check("cont_ex_ready",  ex_ready,   1'b0);
            check("cont_starved",   ex_starved, 1'b0);
            tick();
            check("cont_mem_rg",    rf_wr_rg,   5'(10 + i));
        end
        mem_rd = 5'd13; mem_data = 32'd3;
        settle();
        check("cont3_starved",   ex_starved, 1'b1);
        check("cont3_ex_ready",  ex_ready,   1'b1);
        check("cont3_mem_ready", mem_ready,  1'b0);
        tick();
        check("cont3_rf_rg",   rf_wr_rg,   5'd9);
        check("cont3_rf_data", rf_wr_data, 32'h0000_0099);
        ex_rd = 5'd8; ex_data = 32'h0000_0088;
        settle();
        check("cont4_starved",   ex_starved, 1'b0);
        check("cont4_mem_ready", mem_ready,  1'b1);
        check("cont4_ex_ready",  ex_ready,   1'b0);
        tick();
        check("cont4_rf_rg",   rf_wr_rg,   5'd13);
        ex_valid = 1'b0; mem_valid = 1'b0;
        tick();

        // x0 write is accepted but never writes.
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h0000_1234;
        settle();
        check("x0_mem_ready", mem_ready, 1'b1);
        tick();
        mem_valid = 1'b0;
        check("x0_rf_we", rf_we, 1'b0);
        tick();

        // Hold for four cycles: counter saturates, then EX beats MEM.
        wb_hold = 1'b1;
        ex_valid = 1'b1;  ex_rd = 5'd3;  ex_data = 32'h0000_0033;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h0000_0044;
        for (int h = 0; h < 4; h++) begin
            settle();
            check("hold_ex_ready",  ex_ready,   1'b0);
            check("hold_mem_ready", mem_ready,  1'b0);
            check("hold_starved",   ex_starved, (h == 3) ? 1'b1 : 1'b0);
            tick();
            check("hold_rf_we",     rf_we,      1'b0);
        end
        wb_hold = 1'b0;
        settle();
        check("unhold_starved",   ex_starved, 1'b1);
        check("unhold_ex_ready",  ex_ready,   1'b1);
        check("unhold_mem_ready", mem_ready,  1'b0);
        tick();
        ex_valid = 1'b0;
        check("unhold_rf_rg",   rf_wr_rg,   5'd3);
        check("unhold_rf_data", rf_wr_data, 32'h0000_0033);
        settle();
        check("unhold_mem_next", mem_ready, 1'b1);
        tick();
        mem_valid = 1'b0;
        check("unhold_mem_rg",  rf_wr_rg,   5'd4);
        tick();

`ifdef RF_WB_BYPASS_EN
        // Bypass sees the in-flight write; x0 lookup never hits.
        ex_valid = 1'b1; ex_rd = 5'd7; ex_data = 32'hA5A5_A5A5;
        tick();
        ex_valid = 1'b0;
        byp_rg1 = 5'd7; byp_rg2 = 5'd0;
        settle();
        check("byp_hit1",  byp_hit1,  1'b1);
        check("byp_data1", byp_data1, 32'hA5A5_A5A5);
        check("byp_hit2",  byp_hit2,  1'b0);
        tick();
        check("byp_hit1_idle", byp_hit1, 1'b0);
        byp_rg1 = '0;
`endif

        // Reset mid-operation discards the pending write.
        ex_valid = 1'b1; ex_rd = 5'd6; ex_data = 32'h0000_0066;
        settle();
        check("mid_ex_ready", ex_ready, 1'b1);
        tick();
        check("mid_rf_we_pre", rf_we, 1'b1);
        rst_n = 1'b0;
        settle();
        check("mid_ex_ready_rst", ex_ready, 1'b0);
        tick();
        check("mid_rf_we",   rf_we,    1'b0);
        check("mid_rf_rg",   rf_wr_rg, 5'd0);
        check("mid_starved", ex_starved, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
